vga_bus_writer: RTL and testbench

- 6502-side register interface that sits directly upstream of the VGA timing/framebuffer block.
- Decodes CPU bus accesses into X/Y/COLOR registers.
- Issues single-pixel plot and full-screen clear operations as framebuffer write requests over a valid/ready handshake.
- Runs on the 50 MHz system clock; the CPU bus is asynchronous to it and is synchronised internally.

---
 rtl/vga_bus_writer.sv | 257 +++++++++++++++++++++++++
 tb/tb_vga_bus_writer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_bus_writer.sv
// vga_bus_writer: 6502 register port that turns CPU writes into framebuffer
// plot/clear requests. Define VGA_RECT_FILL_EN to add rectangle fill (W/H regs).
module vga_bus_writer #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic       RW,
  input  logic [2:0] A,
  input  logic [7:0] DATA,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       FB_WE,
  input  logic       FB_READY,
  output logic [7:0] FB_X,
  output logic [6:0] FB_Y,
  output logic [2:0] FB_COLOR
);
  localparam logic [8:0] W9   = 9'(FB_W);
  localparam logic [8:0] H9   = 9'(FB_H);
  localparam logic [7:0] XMAX = 8'(FB_W - 1);
  localparam logic [6:0] YMAX = 7'(FB_H - 1);

`ifdef VGA_RECT_FILL_EN
  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_CLEAR, S_RECT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_CLEAR} state_t;
`endif

  state_t r_state, w_state_n;

  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic       r_ce_prev;
  logic       r_rw;
  logic [2:0] r_a;
  logic [7:0] r_data;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_color;
  logic       r_ovr;
  logic [7:0] r_fb_x;
  logic [6:0] r_fb_y;
  logic [2:0] r_fb_color;

  logic w_ce_s, w_rise, w_wr, w_busy, w_acc;
  logic w_plot, w_clr, w_rect, w_inrng, w_inc;

  assign w_ce_s  = r_ce_sync[SYNC_STAGES-1];
  assign w_rise  = w_ce_s & ~r_ce_prev;
  assign w_wr    = w_rise & ~r_rw;
  assign w_busy  = (r_state != S_IDLE);
  assign w_acc   = FB_WE & FB_READY;
  assign w_plot  = w_wr & (r_a == 3'd3);
  assign w_clr   = w_wr & (r_a == 3'd4) & (r_data == 8'h01);
  assign w_inrng = ({1'b0, r_x} < W9) && ({2'b0, r_y} < H9);
  assign w_inc   = ((r_state == S_PLOT) && w_acc)
                 || (!w_busy && w_plot && !w_inrng);

  assign DOE      = ~w_ce_s & r_rw;
  assign FB_WE    = w_busy;
  assign FB_X     = r_fb_x;
  assign FB_Y     = r_fb_y;
  assign FB_COLOR = r_fb_color;

`ifdef VGA_RECT_FILL_EN
  logic [7:0] r_w, r_x0, r_xe;
  logic [6:0] r_h, r_ye;
  logic [8:0] w_xsum, w_ysum;
  logic [7:0] w_xe;
  logic [6:0] w_ye;
  logic       w_rect_ok;

  // Sums are 9 bits wide so a far-right/bottom rectangle clips instead of wrapping
  assign w_xsum    = {1'b0, r_x} + {1'b0, r_w};
  assign w_ysum    = {2'b0, r_y} + {2'b0, r_h};
  assign w_xe      = (w_xsum > W9) ? XMAX : 8'(w_xsum - 9'd1);
  assign w_ye      = (w_ysum > H9) ? YMAX : 7'(w_ysum - 9'd1);
  assign w_rect    = w_wr & (r_a == 3'd4) & (r_data == 8'h02);
  assign w_rect_ok = (r_w != 8'd0) && (r_h != 7'd0) && w_inrng;
`else
  assign w_rect = 1'b0;
`endif

  always_comb begin
    DOUT = 8'h00;
    case (r_a)
      3'd0: DOUT = r_x;
      3'd1: DOUT = {1'b0, r_y};
      3'd2: DOUT = {5'b0, r_color};
      3'd4: DOUT = {6'b0, r_ovr, w_busy};
`ifdef VGA_RECT_FILL_EN
      3'd5: DOUT = r_w;
      3'd6: DOUT = {1'b0, r_h};
`endif
      default: DOUT = 8'h00;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_plot && w_inrng)   w_state_n = S_PLOT;
        else if (w_clr)          w_state_n = S_CLEAR;
`ifdef VGA_RECT_FILL_EN
        else if (w_rect && w_rect_ok) w_state_n = S_RECT;
`endif
      end
      S_PLOT:
        if (w_acc) w_state_n = S_IDLE;
      S_CLEAR:
        if (w_acc && r_fb_x == XMAX && r_fb_y == YMAX)
          w_state_n = S_IDLE;
`ifdef VGA_RECT_FILL_EN
      S_RECT:
        if (w_acc && r_fb_x == r_xe && r_fb_y == r_ye)
          w_state_n = S_IDLE;
`endif
      default: w_state_n = S_IDLE;
    endcase
  end

  // CE idles high, so the synchroniser resets to the inactive level
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ce_sync <= '1;
      r_ce_prev <= 1'b1;
      r_rw      <= 1'b0;
      r_a       <= 3'd0;
      r_data    <= 8'd0;
    end else begin
      r_ce_sync <= {r_ce_sync[SYNC_STAGES-2:0], CE};
      r_ce_prev <= w_ce_s;
      if (!w_ce_s) begin
        r_rw   <= RW;
        r_a    <= A;
        r_data <= DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_x     <= 8'd0;
      r_y     <= 7'd0;
      r_color <= 3'd0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_inc) begin
        if (r_x == XMAX) begin
          r_x <= 8'd0;
          r_y <= (r_y == YMAX) ? 7'd0 : r_y + 7'd1;
        end else begin
          r_x <= r_x + 8'd1;
        end
      end
      // A CPU register write lands after the auto-increment and wins
      if (w_wr) begin
        case (r_a)
          3'd0: r_x     <= r_data;
          3'd1: r_y     <= r_data[6:0];
          3'd2: r_color <= r_data[2:0];
          3'd3: if (!w_busy) r_color <= r_data[2:0];
          default: ;
        endcase
      end
      if (w_busy && w_wr && (r_a == 3'd3 || r_a == 3'd4))
        r_ovr <= 1'b1;
      else if (w_rise && r_rw && r_a == 3'd4)
        r_ovr <= 1'b0;
    end
  end

`ifdef VGA_RECT_FILL_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_w  <= 8'd0;
      r_h  <= 7'd0;
      r_x0 <= 8'd0;
      r_xe <= 8'd0;
      r_ye <= 7'd0;
    end else begin
      if (w_wr && r_a == 3'd5) r_w <= r_data;
      if (w_wr && r_a == 3'd6) r_h <= r_data[6:0];
      if (!w_busy && w_rect && w_rect_ok) begin
        r_x0 <= r_x;
        r_xe <= w_xe;
        r_ye <= w_ye;
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fb_x     <= 8'd0;
      r_fb_y     <= 7'd0;
      r_fb_color <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_plot && w_inrng) begin
            r_fb_x     <= r_x;
            r_fb_y     <= r_y;
            r_fb_color <= r_data[2:0];
          end else if (w_clr) begin
            r_fb_x     <= 8'd0;
            r_fb_y     <= 7'd0;
            r_fb_color <= r_color;
          end
`ifdef VGA_RECT_FILL_EN
          else if (w_rect && w_rect_ok) begin
            r_fb_x     <= r_x;
            r_fb_y     <= r_y;
            r_fb_color <= r_color;
          end
`endif
        end
        S_CLEAR: begin
          if (w_acc) begin
            if (r_fb_x == XMAX) begin
              r_fb_x <= 8'd0;
              r_fb_y <= r_fb_y + 7'd1;
            end else begin
              r_fb_x <= r_fb_x + 8'd1;
            end
          end
        end
`ifdef VGA_RECT_FILL_EN
        S_RECT: begin
          if (w_acc) begin
            if (r_fb_x == r_xe) begin
              r_fb_x <= r_x0;
              r_fb_y <= r_fb_y + 7'd1;
            end else begin
              r_fb_x <= r_fb_x + 8'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_bus_writer.sv
// tb_vga_bus_writer: directed bench with a scoreboard of expected
// framebuffer writes {x,y,color}, checked by a monitor on each accept.
module tb_vga_bus_writer;
  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CE;
  logic       RW;
  logic [2:0] A;
  logic [7:0] DATA;
  logic [7:0] DOUT;
  logic       DOE;
  logic       FB_WE;
  logic       FB_READY;
  logic [7:0] FB_X;
  logic [6:0] FB_Y;
  logic [2:0] FB_COLOR;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 1;
  bit sb_en = 1'b1;
  logic [17:0] sb_q[$];
  logic [7:0] rd;

  vga_bus_writer #(.FB_W(160), .FB_H(120), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .RW(RW), .A(A),
    .DATA(DATA), .DOUT(DOUT), .DOE(DOE), .FB_WE(FB_WE),
    .FB_READY(FB_READY), .FB_X(FB_X), .FB_Y(FB_Y),
    .FB_COLOR(FB_COLOR)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    FB_READY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0:       FB_READY = 1'b0;
        1:       FB_READY = 1'b1;
        default: FB_READY = ~FB_READY;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (sb_en && RESET_N && FB_WE && FB_READY) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_fb_write", {14'b0, FB_X, FB_Y, FB_COLOR}, 32'hFFFFFFFF);
      end else begin
        chk("fb_write", {14'b0, FB_X, FB_Y, FB_COLOR},
            {14'b0, sb_q.pop_front()});
      end
    end
  end

  task automatic push(input int x, input int y, input int c);
    sb_q.push_back({8'(x), 7'(y), 3'(c)});
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    RW = 1'b0; A = a; DATA = d; CE = 1'b0;
    repeat (4) @(posedge CLK);
    #1 CE = 1'b1;
    repeat (4) @(posedge CLK);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    @(posedge CLK); #1;
    RW = 1'b1; A = a; CE = 1'b0;
    repeat (4) @(posedge CLK);
    #1 d = DOUT;
    chk("doe_on_read", {31'b0, DOE}, 32'd1);
    CE = 1'b1;
    repeat (4) @(posedge CLK);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge CLK);
    while (FB_WE && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {31'b0, FB_WE}, 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; CE = 1'b1; RW = 1'b1; A = 3'd0; DATA = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", {DOUT, 4'b0, DOE, FB_WE, FB_X, FB_Y, FB_COLOR},
        32'd0);
    RESET_N = 1'b1;

    // plot with ready high
    rdy_mode = 1;
    cpu_write(3'd0, 8'd10);
    cpu_write(3'd1, 8'd20);
    push(10, 20, 5);
    cpu_write(3'd3, 8'h05);
    wait_idle("plot1_done", 20);
    chk("plot1_sb_empty", sb_q.size(), 0);
    cpu_read(3'd0, rd); chk("x_after_plot", {24'b0, rd}, 32'd11);
    cpu_read(3'd1, rd); chk("y_after_plot", {24'b0, rd}, 32'd20);
    cpu_read(3'd2, rd); chk("color_after_plot", {24'b0, rd}, 32'd5);
    cpu_read(3'd4, rd); chk("status_idle", {24'b0, rd}, 32'd0);

    // corner plot with backpressure, wraps X/Y to 0
    rdy_mode = 0;
    cpu_write(3'd0, 8'd159);
    cpu_write(3'd1, 8'd119);
    push(159, 119, 3);
    cpu_write(3'd3, 8'h03);
    repeat (5) begin
      @(negedge CLK);
      chk("plot_hold", {14'b0, FB_WE, FB_X, FB_Y, FB_COLOR},
          {14'b0, 1'b1, 8'd159, 7'd119, 3'd3});
    end
    rdy_mode = 1;
    wait_idle("plot2_done", 20);
    chk("plot2_sb_empty", sb_q.size(), 0);
    cpu_read(3'd0, rd); chk("x_wrap", {24'b0, rd}, 32'd0);
    cpu_read(3'd1, rd); chk("y_wrap", {24'b0, rd}, 32'd0);

    // out-of-range plot: no write, X still increments
    cpu_write(3'd0, 8'd200);
    cpu_write(3'd1, 8'd5);
    cpu_write(3'd3, 8'h01);
    repeat (4) @(posedge CLK);
    cpu_read(3'd0, rd); chk("x_oor_inc", {24'b0, rd}, 32'd201);
    cpu_read(3'd4, rd); chk("status_oor", {24'b0, rd}, 32'd0);
    cpu_write(3'd0, 8'd0);
    cpu_write(3'd1, 8'd0);

    // full clear with 50% ready and an overrun attempt
    cpu_write(3'd2, 8'd2);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        push(x, y, 2);
    rdy_mode = 2;
    cpu_write(3'd4, 8'h01);
    cpu_write(3'd3, 8'h07);
    cpu_read(3'd4, rd); chk("status_ovr_busy", {24'b0, rd}, 32'd3);
    cpu_read(3'd4, rd); chk("status_busy", {24'b0, rd}, 32'd1);
    wait_idle("clear_done", 45000);
    chk("clear_sb_empty", sb_q.size(), 0);
    rdy_mode = 1;
    cpu_read(3'd4, rd); chk("status_after_clear", {24'b0, rd}, 32'd0);
    cpu_read(3'd0, rd); chk("x_after_clear", {24'b0, rd}, 32'd0);

    // reset in the middle of a clear
    cpu_write(3'd0, 8'd5);
    cpu_write(3'd1, 8'd7);
    sb_en = 1'b0;
    cpu_write(3'd4, 8'h01);
    repeat (20) @(posedge CLK);
    #1 RESET_N = 1'b0;
    #1 chk("reset_fb_we", {31'b0, FB_WE}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    sb_en = 1'b1;
    repeat (50) @(posedge CLK);
    cpu_read(3'd4, rd); chk("status_post_rst", {24'b0, rd}, 32'd0);
    cpu_read(3'd0, rd); chk("x_post_rst", {24'b0, rd}, 32'd0);
    cpu_read(3'd1, rd); chk("y_post_rst", {24'b0, rd}, 32'd0);

`ifdef VGA_RECT_FILL_EN
    cpu_write(3'd0, 8'd150);
    cpu_write(3'd1, 8'd115);
    cpu_write(3'd5, 8'd20);
    cpu_write(3'd6, 8'd10);
    cpu_write(3'd2, 8'd6);
    for (int y = 115; y < 120; y++)
      for (int x = 150; x < 160; x++)
        push(x, y, 6);
    cpu_write(3'd4, 8'h02);
    wait_idle("rect_done", 500);
    chk("rect_sb_empty", sb_q.size(), 0);
    cpu_read(3'd5, rd); chk("w_readback", {24'b0, rd}, 32'd20);
`else
    cpu_write(3'd4, 8'h02);
    repeat (10) @(posedge CLK);
    cpu_read(3'd4, rd); chk("rect_ignored", {24'b0, rd}, 32'd0);
    cpu_read(3'd5, rd); chk("a5_reads_zero", {24'b0, rd}, 32'd0);
`endif
    repeat (10) @(posedge CLK);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
